// File: rtl/icache_dm_refill.sv
// Direct-mapped, read-only instruction cache with multi-beat line refill,
// whole-cache flush and hit/miss counters.
module icache_dm_refill #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SET_NUM    = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-3:0] cpu_addr,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [31:0]           cpu_rdata,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);
    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SET_NUM);
    localparam int TAG_W = WA_W - OFF_W - IDX_W;
    localparam int BC_W  = OFF_W + 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
    state_t state;

    logic [SET_NUM-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [SET_NUM];
    logic [31:0]        data_mem [SET_NUM*LINE_WORDS];
    logic               flush_pending;

    logic [TAG_W-1:0]   tag_l;
    logic [IDX_W-1:0]   idx_l;
    logic [OFF_W-1:0]   off_l;
    logic [BC_W-1:0]    req_cnt;
    logic [BC_W-1:0]    rsp_cnt;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic               hit;
    logic               accept;
    logic               miss_accept;
    logic               refill_beat;

    assign req_tag     = cpu_addr[WA_W-1 -: TAG_W];
    assign req_idx     = cpu_addr[OFF_W +: IDX_W];
    assign req_off     = cpu_addr[OFF_W-1:0];
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign cpu_ready   = (state == IDLE) && !flush && !flush_pending;
    assign accept      = cpu_req && cpu_ready;
    assign miss_accept = accept && !hit;
    assign refill_beat = (state == REFILL) && mem_rvalid;
    // Counter MSB only matters for the end-of-line compare; low bits walk the line.
    assign mem_addr    = {tag_l, idx_l, req_cnt[OFF_W-1:0]};

    // Arrays and the latched miss address carry no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (miss_accept) begin
                tag_l <= req_tag;
                idx_l <= req_idx;
                off_l <= req_off;
            end
            if (refill_beat) begin
                data_mem[{idx_l, rsp_cnt[OFF_W-1:0]}] <= mem_rdata;
                if (rsp_cnt == LAST_BEAT) begin
                    tag_mem[idx_l] <= tag_l;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            flush_pending <= 1'b0;
            cpu_rvalid    <= 1'b0;
            cpu_rdata     <= '0;
            mem_req       <= 1'b0;
            req_cnt       <= '0;
            rsp_cnt       <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush || flush_pending) begin
                        valid         <= '0;
                        flush_pending <= 1'b0;
                    end else if (cpu_req) begin
                        if (hit) begin
                            cpu_rdata  <= data_mem[{req_idx, req_off}];
                            cpu_rvalid <= 1'b1;
                            hit_cnt    <= hit_cnt + CNT_WIDTH'(1);
                        end else begin
                            miss_cnt       <= miss_cnt + CNT_WIDTH'(1);
                            valid[req_idx] <= 1'b0;
                            req_cnt        <= '0;
                            rsp_cnt        <= '0;
                            mem_req        <= 1'b1;
                            state          <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (mem_req && mem_ready) begin
                        req_cnt <= req_cnt + BC_W'(1);
                        if (req_cnt == LAST_BEAT) begin
                            mem_req <= 1'b0;
                        end
                    end
                    if (mem_rvalid) begin
                        rsp_cnt <= rsp_cnt + BC_W'(1);
                        if (rsp_cnt == LAST_BEAT) begin
                            valid[idx_l] <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    // The last beat was written on the previous edge, so the line is readable now.
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    cpu_rdata  <= data_mem[{idx_l, off_l}];
                    cpu_rvalid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_dm_refill.sv
// Scoreboard bench for icache_dm_refill: directed fetches against a small
// word-wide memory model with configurable delay and back-pressure.
module tb_icache_dm_refill;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [29:0] cpu_addr = '0;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_dm_refill #(
        .ADDR_WIDTH(32),
        .LINE_WORDS(4),
        .SET_NUM(64),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .flush(flush),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int stall_left = 0;
    int hold_n = 0;

    logic [31:0] exp_rd[$];
    logic [31:0] exp_mem[$];
    logic [29:0] pend_addr[$];
    int          pend_due[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Line at byte 0x10 holds A0..A3; line at 0x410 holds B0..B3.
    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return 32'hA0 + 32'(wa[1:0]) + ((32'(wa) >> 8) * 32'd16);
    endfunction

    // Memory model: one beat per accepted request, in order, two cycles later.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (stall_left > 0 && mem_req === 1'b1) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        if (mem_req === 1'b1 && mem_ready) begin
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + 2);
        end
    end

    // CPU response monitor.
    always begin
        @(negedge clk);
        #1;
        if (cpu_rvalid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                checks++;
                $display("FAIL spurious_rvalid: got rdata %0h with no request outstanding", cpu_rdata);
            end else begin
                chk("cpu_rdata", cpu_rdata, exp_rd.pop_front());
            end
        end
    end

    // Refill request monitor: order, addresses and stability under back-pressure.
    logic        hold_pending = 1'b0;
    logic [29:0] hold_addr = '0;
    always begin
        @(negedge clk);
        #1;
        if (mem_req === 1'b1 && mem_ready) begin
            if (exp_mem.size() == 0) begin
                checks++;
                $display("FAIL unexpected_mem_req: got byte addr %0h with none expected", {mem_addr, 2'b00});
            end else begin
                chk("mem_addr", {mem_addr, 2'b00}, exp_mem.pop_front());
            end
        end
        if (mem_req === 1'b1 && hold_pending) begin
            hold_n++;
            chk("mem_addr_hold", mem_addr, hold_addr);
        end
        hold_pending = (mem_req === 1'b1) && !mem_ready;
        hold_addr    = mem_addr;
    end

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem.push_back(base + 32'(i * 4));
    endtask

    task automatic issue(input logic [31:0] byte_addr, input logic [31:0] exp);
        int n = 0;
        exp_rd.push_back(exp);
        cpu_req  = 1'b1;
        cpu_addr = byte_addr[31:2];
        while (cpu_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cpu_accept", cpu_ready, 1);
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rd.size() != 0 || exp_mem.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_rd.size() + exp_mem.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int beats;
        int c0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", cpu_ready, 1);

        // Cold miss on byte 0x18
        push_line(32'h10);
        issue(32'h18, 32'hA2);
        drain("cold_drain");
        chk("cold_miss_cnt", miss_cnt, 1);
        chk("cold_hit_cnt", hit_cnt, 0);

        // Hit streaming, one request per cycle
        c0 = cyc;
        issue(32'h10, 32'hA0);
        issue(32'h14, 32'hA1);
        issue(32'h1C, 32'hA3);
        chk("hit_throughput_cycles", cyc - c0, 3);
        drain("hit_drain");
        chk("hit_cnt_3", hit_cnt, 3);
        chk("hit_miss_cnt", miss_cnt, 1);

        // Conflict misses on the same index
        push_line(32'h410);
        issue(32'h418, 32'hB2);
        drain("conf1_drain");
        chk("conf1_miss_cnt", miss_cnt, 2);
        push_line(32'h10);
        issue(32'h18, 32'hA2);
        drain("conf2_drain");
        chk("conf2_miss_cnt", miss_cnt, 3);

        // Flush during a refill
        push_line(32'h410);
        issue(32'h418, 32'hB2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (cpu_rvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("flush_rvalid", cpu_rvalid, 1);
        chk("flush_idle_not_ready", cpu_ready, 0);
        @(negedge clk);
        chk("flush_ready_back", cpu_ready, 1);
        drain("flush_drain");
        push_line(32'h10);
        issue(32'h10, 32'hA0);
        drain("post_flush_drain");
        chk("post_flush_miss_cnt", miss_cnt, 5);
        chk("post_flush_hit_cnt", hit_cnt, 3);

        // Reset after two refill beats
        push_line(32'h410);
        issue(32'h418, 32'hB2);
        beats = 0;
        n = 0;
        while (beats < 2 && n < 100) begin
            @(negedge clk);
            #1;
            if (mem_rvalid) beats++;
            n++;
        end
        chk("rst_beats_seen", beats, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_hit_cnt", hit_cnt, 0);
        chk("midrst_miss_cnt", miss_cnt, 0);
        chk("midrst_rvalid", cpu_rvalid, 0);
        chk("midrst_rdata", cpu_rdata, 0);
        exp_rd.delete();
        exp_mem.delete();
        repeat (6) @(negedge clk);
        push_line(32'h10);
        issue(32'h10, 32'hA0);
        drain("after_rst_drain");
        chk("after_rst_miss_cnt", miss_cnt, 1);
        chk("after_rst_hit_cnt", hit_cnt, 0);

        // Back-pressure on beat 0
        hold_n = 0;
        stall_left = 5;
        push_line(32'h410);
        issue(32'h41C, 32'hB3);
        issue(32'h410, 32'hB0);
        issue(32'h414, 32'hB1);
        drain("stall_drain");
        chk("stall_hold_count", hold_n, 5);
        chk("stall_miss_cnt", miss_cnt, 2);
        chk("stall_hit_cnt", hit_cnt, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
